strobe_sequencer: RTL and testbench
===================================

Name: strobe_sequencer

Overview:
Upstream driver for the 3-to-8 one-hot strobe decoder. It takes a start request with a first index and a strobe count. It then issues a run of consecutive `sel` values with `enable`, one strobe per issue cycle. Hold/stall, abort and a done pulse are provided so the microcode sequencer can fire a burst of register-load or bus-phase strobes through the decoder without cycling `sel` itself.

Parameters:
GAP, 0, idle cycles inserted between consecutive strobes (legal 0..3); 0 gives back-to-back strobes.

Ports:
sysclk  input  1  system clock; all state changes on rising edge
sys_rst  input  1  reset; asynchronous, active-high
start  input  1  burst request; sampled only in IDLE
first_sel  input  3  index of first strobe; latched on accepted start
count  input  3  strobes minus one (0 → 1 strobe, 7 → 8 strobes); latched on accepted start
hold  input  1  stall; suppresses the current strobe and freezes advance
abort  input  1  cancel burst; return to IDLE
enable  output  1  decoder enable; combinational from state/hold/abort
sel  output  3  decoder select; registered
busy  output  1  high in ISSUE and GAP states
done  output  1  one-cycle pulse after the last strobe of a burst

Behaviour:
- Reset (async, sys_rst=1): state=IDLE, sel=0, remaining=0, gap counter=0, enable=0, busy=0, done=0. Asserting reset mid-burst kills it immediately; no done pulse.
- States: IDLE, ISSUE, GAP, DONE; 2-bit encoding.
- IDLE: enable=0, busy=0, done=0. If start=1 and abort=0 at an edge: sel<=first_sel, remaining<=count, go ISSUE. If abort=1, start is ignored.
- ISSUE: busy=1; enable = ~hold & ~abort.
  - hold=1 (abort=0): stay in ISSUE; sel and remaining unchanged; the strobe is retried next cycle.
  - Strobe taken (enable=1 at the edge) with remaining==0: go DONE.
  - Strobe taken with remaining!=0:
    - remaining<=remaining-1.
    - sel<=sel+1 modulo 8 (7 wraps to 0).
    - Next state: GAP with gap counter<=GAP-1 if GAP>0; otherwise stay in ISSUE.
- GAP: busy=1, enable=0. Gap counter decrements every cycle regardless of hold. When it reaches 0, go ISSUE.
- DONE: done=1 for exactly one cycle, busy=0, enable=0; unconditionally go IDLE. start asserted during DONE is ignored; it must be re-presented in IDLE.
- abort=1 in ISSUE or GAP: enable forced 0 in that cycle; next state IDLE; no done pulse; sel keeps its last value. abort overrides hold.
- Latency:
  - Start accepted at edge N → first enable in the cycle after edge N.
  - With GAP=0 and no hold, a burst of count+1 strobes occupies count+1 contiguous cycles.
  - done is high in the cycle immediately after the last strobe.
- Throughput: minimum start-to-start spacing is count+1 + count*GAP + 2 cycles (DONE cycle plus the IDLE accept cycle).
- sel only changes on taken strobes and on start accept, so the decoder never sees a glitching index while enable=1.
- count and first_sel changes during a burst have no effect.

Optional Feature:
STROBE_SEQ_DIR_EN
- Defined: adds input port `dir_down` (1 bit), latched on accepted start. dir_down=1 makes sel decrement modulo 8 on each taken strobe (0 wraps to 7); dir_down=0 behaves exactly as the base block.
- Undefined: port absent; sel always increments.

Test Plan:
- Reset mid-burst: start first_sel=2 count=5, assert sys_rst in 2nd strobe cycle → enable, busy, done 0 asynchronously; sel=0; no done pulse after reset release.
- Basic burst, GAP=0: first_sel=3 count=2 → enable high 3 consecutive cycles with sel=3,4,5; done high in the next cycle; busy low again.
- Wrap and GAP=2: first_sel=6 count=3 → strobes sel=6,7,0,1, each separated by exactly 2 enable-low cycles; done one cycle after the sel=1 strobe.
- Hold: first_sel=0 count=1, hold=1 for 3 cycles during the first strobe → enable low, sel=0 for those 3 cycles; then sel=0 strobe, sel=1 strobe, done.
- Abort: first_sel=4 count=7, abort on 3rd strobe cycle (hold also 1) → enable 0 that cycle, IDLE next, no done, sel=6 retained; start+abort together in IDLE → not accepted.
- With STROBE_SEQ_DIR_EN, dir_down=1: first_sel=1 count=2 → strobes sel=1,0,7; then done.

Source files
------------

// File: rtl/strobe_sequencer.sv
// Burst driver for the 3-to-8 one-hot strobe decoder: issues count+1 consecutive sel values with enable.
// Optional macro STROBE_SEQ_DIR_EN adds dir_down so a burst can walk sel downwards.
module strobe_sequencer #(
  parameter int unsigned GAP = 0
) (
  input  logic       sysclk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [2:0] first_sel,
  input  logic [2:0] count,
`ifdef STROBE_SEQ_DIR_EN
  input  logic       dir_down,
`endif
  input  logic       hold,
  input  logic       abort,
  output logic       enable,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Gap counter is loaded with GAP-1 so the GAP state lasts exactly GAP cycles.
  localparam logic [1:0] GAP_LD = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  state_t     r_state, w_next;
  logic [2:0] r_sel, w_sel_nxt;
  logic [2:0] r_rem, w_rem_nxt;
  logic [1:0] r_gap, w_gap_nxt;
  logic [2:0] w_sel_step;
  logic       w_take;
  logic       w_accept;

  assign w_accept = (r_state == S_IDLE) & start & ~abort;
  assign w_take   = (r_state == S_ISSUE) & ~hold & ~abort;

`ifdef STROBE_SEQ_DIR_EN
  logic r_dir;

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst)       r_dir <= 1'b0;
    else if (w_accept) r_dir <= dir_down;
  end

  assign w_sel_step = r_dir ? (r_sel - 3'd1) : (r_sel + 3'd1);
`else
  assign w_sel_step = r_sel + 3'd1;
`endif

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_sel   <= 3'd0;
      r_rem   <= 3'd0;
      r_gap   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_sel   <= w_sel_nxt;
      r_rem   <= w_rem_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // sel moves only on accept or a taken strobe, so it is stable whenever enable is high.
  always_comb begin
    w_next    = r_state;
    w_sel_nxt = r_sel;
    w_rem_nxt = r_rem;
    w_gap_nxt = r_gap;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next    = S_ISSUE;
          w_sel_nxt = first_sel;
          w_rem_nxt = count;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_take) begin
          if (r_rem == 3'd0) begin
            w_next = S_DONE;
          end else begin
            w_rem_nxt = r_rem - 3'd1;
            w_sel_nxt = w_sel_step;
            if (GAP > 0) begin
              w_next    = S_GAP;
              w_gap_nxt = GAP_LD;
            end
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (r_gap == 2'd0) begin
          w_next = S_ISSUE;
        end else begin
          w_gap_nxt = r_gap - 2'd1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign enable = w_take;
  assign sel    = r_sel;
  assign busy   = (r_state == S_ISSUE) | (r_state == S_GAP);
  assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_strobe_sequencer.sv
// Randomized scoreboard bench: two sequencers (GAP=0 and GAP=2) share stimulus; a burst-level model predicts strobes/done.
module tb_strobe_sequencer;
  localparam int MAXC = 16384;
  localparam int MAXO = 128;

  logic       sysclk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0, hold = 1'b0, abort = 1'b0, dir_down = 1'b0;
  logic [2:0] first_sel = 3'd0, count = 3'd0;
  logic       en0, en1, busy0, busy1, done0, done1;
  logic [2:0] sel0, sel1;

  strobe_sequencer #(.GAP(0)) u_g0 (
    .sysclk(sysclk), .sys_rst(sys_rst), .start(start), .first_sel(first_sel), .count(count),
`ifdef STROBE_SEQ_DIR_EN
    .dir_down(dir_down),
`endif
    .hold(hold), .abort(abort), .enable(en0), .sel(sel0), .busy(busy0), .done(done0));

  strobe_sequencer #(.GAP(2)) u_g2 (
    .sysclk(sysclk), .sys_rst(sys_rst), .start(start), .first_sel(first_sel), .count(count),
`ifdef STROBE_SEQ_DIR_EN
    .dir_down(dir_down),
`endif
    .hold(hold), .abort(abort), .enable(en1), .sel(sel1), .busy(busy1), .done(done1));

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  typedef struct {
    int         cyc;
    bit         is_done;
    logic [2:0] sel;
  } ev_t;
  ev_t q0[$], q1[$];

  bit         exp_vld [2][MAXC];
  bit         exp_busy[2][MAXC];
  logic [2:0] exp_sel [2][MAXC];
  logic [2:0] m_sel[2];
  bit         hv[MAXO];
  bit         av[MAXO];

  task automatic chk(input string nm, input int gl, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s gap%0d cyc=%0d got=%0d want=%0d", nm, gl, cyc, act, expv);
    end
  endtask

  function automatic void set_exp(int d, int t, bit b, logic [2:0] s);
    if (t < MAXC) begin
      exp_vld[d][t]  = 1'b1;
      exp_busy[d][t] = b;
      exp_sel[d][t]  = s;
    end
  endfunction

  function automatic void push_ev(int d, int t, bit isd, logic [2:0] s);
    ev_t e;
    e.cyc = t; e.is_done = isd; e.sel = s;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Burst timeline from the rules: strobe k goes out at the first non-held cycle, then g idle cycles.
  // Returns the first cycle the block is back in IDLE.
  function automatic int plan(int d, int g, int cs, logic [2:0] f, logic [2:0] n, bit dn);
    int t = cs + 1;
    int k = 0;
    int off;
    logic [2:0] s = f;
    while (1) begin
      off = t - cs;
      set_exp(d, t, 1'b1, s);
      if (off < MAXO && av[off]) begin m_sel[d] = s; return t + 1; end
      if (off < MAXO && hv[off]) begin t++; continue; end
      push_ev(d, t, 1'b0, s);
      if (k == int'(n)) begin
        set_exp(d, t + 1, 1'b0, s);
        push_ev(d, t + 1, 1'b1, s);
        m_sel[d] = s;
        return t + 2;
      end
      k++;
      s = dn ? (s - 3'd1) : (s + 3'd1);
      t++;
      for (int i = 0; i < g; i++) begin
        off = t - cs;
        set_exp(d, t, 1'b1, s);
        if (off < MAXO && av[off]) begin m_sel[d] = s; return t + 1; end
        t++;
      end
    end
    return t;
  endfunction

  task automatic mon(input int d, input logic en, input logic [2:0] s, input logic b, input logic dn);
    ev_t e;
    int gl = d * 2;
    if (cyc < MAXC && exp_vld[d][cyc]) begin
      chk("busy", gl, int'(b), int'(exp_busy[d][cyc]));
      chk("sel", gl, int'(s), int'(exp_sel[d][cyc]));
    end
    while ((d == 0 ? q0.size() : q1.size()) > 0 &&
           (d == 0 ? q0[0].cyc : q1[0].cyc) < cyc) begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk("missed_event", gl, cyc, e.cyc);
    end
    if (en === 1'b1 || dn === 1'b1) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        chk("unexpected_output", gl, int'({en, dn}), 0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("event_cycle", gl, cyc, e.cyc);
        chk("done", gl, int'(dn), int'(e.is_done));
        chk("enable", gl, int'(en), int'(!e.is_done));
        if (!e.is_done) chk("strobe_sel", gl, int'(s), int'(e.sel));
      end
    end
  endtask

  always @(negedge sysclk) begin
    if (chk_on) begin
      mon(0, en0, sel0, busy0, done0);
      mon(1, en1, sel1, busy1, done1);
    end
  end

  task automatic next_cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_exp(input int c);
    set_exp(0, c, 1'b0, m_sel[0]);
    set_exp(1, c, 1'b0, m_sel[1]);
  endtask

  task automatic run_burst(input logic [2:0] f, input logic [2:0] n, input bit dn);
    int cs, e0, e1, emin, emax;
    cs = cyc;
    start = 1'b1; first_sel = f; count = n; dir_down = dn; hold = 1'b0; abort = 1'b0;
    idle_exp(cs);
    e0 = plan(0, 0, cs, f, n, dn);
    e1 = plan(1, 2, cs, f, n, dn);
    emin = (e0 < e1) ? e0 : e1;
    emax = (e0 > e1) ? e0 : e1;
    for (int c = cs + 1; c < emax; c++) begin
      next_cyc();
      // stray start/first_sel/count while busy (incl. the DONE cycle) must be ignored
      start     = (c < emin) ? 1'($urandom_range(0, 1)) : 1'b0;
      first_sel = 3'($urandom_range(0, 7));
      count     = 3'($urandom_range(0, 7));
      dir_down  = 1'($urandom_range(0, 1));
      hold      = (c - cs < MAXO) ? hv[c - cs] : 1'b0;
      abort     = (c - cs < MAXO) ? av[c - cs] : 1'b0;
      if (c >= e0) set_exp(0, c, 1'b0, m_sel[0]);
      if (c >= e1) set_exp(1, c, 1'b0, m_sel[1]);
    end
    next_cyc();
    start = 1'b0; hold = 1'b0; abort = 1'b0;
    idle_exp(cyc);
    for (int i = 0; i < MAXO; i++) begin hv[i] = 1'b0; av[i] = 1'b0; end
  endtask

  task automatic start_abort_idle();
    start = 1'b1; abort = 1'b1; first_sel = 3'($urandom_range(0, 7));
    idle_exp(cyc);
    next_cyc();
    start = 1'b0; abort = 1'b0;
    idle_exp(cyc);
    next_cyc();
    idle_exp(cyc);
  endtask

  initial begin
    bit dn;
    #12;
    chk("rst_enable", 0, int'(en0), 0);   chk("rst_enable", 2, int'(en1), 0);
    chk("rst_busy", 0, int'(busy0), 0);   chk("rst_busy", 2, int'(busy1), 0);
    chk("rst_done", 0, int'(done0), 0);   chk("rst_done", 2, int'(done1), 0);
    chk("rst_sel", 0, int'(sel0), 0);     chk("rst_sel", 2, int'(sel1), 0);
    next_cyc();
    sys_rst = 1'b0;
    next_cyc();
    start = 1'b1; first_sel = 3'd2; count = 3'd5;
    next_cyc();
    start = 1'b0;
    chk("first_strobe_en", 0, int'(en0), 1);
    chk("first_strobe_sel", 0, int'(sel0), 2);
    next_cyc();
    chk("second_strobe_sel", 0, int'(sel0), 3);
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst_enable", 0, int'(en0), 0); chk("midrst_enable", 2, int'(en1), 0);
    chk("midrst_busy", 0, int'(busy0), 0); chk("midrst_busy", 2, int'(busy1), 0);
    chk("midrst_done", 0, int'(done0), 0); chk("midrst_done", 2, int'(done1), 0);
    chk("midrst_sel", 0, int'(sel0), 0);   chk("midrst_sel", 2, int'(sel1), 0);
    repeat (2) next_cyc();
    sys_rst = 1'b0;
    repeat (6) begin
      @(negedge sysclk);
      chk("postrst_done", 0, int'(done0), 0); chk("postrst_done", 2, int'(done1), 0);
      chk("postrst_enable", 0, int'(en0), 0); chk("postrst_enable", 2, int'(en1), 0);
    end
    next_cyc();
    m_sel[0] = 3'd0; m_sel[1] = 3'd0;
    idle_exp(cyc);
    chk_on = 1'b1;

    run_burst(3'd3, 3'd2, 1'b0);
    run_burst(3'd6, 3'd3, 1'b0);
    hv[1] = 1'b1; hv[2] = 1'b1; hv[3] = 1'b1;
    run_burst(3'd0, 3'd1, 1'b0);
    hv[3] = 1'b1; av[3] = 1'b1;
    run_burst(3'd4, 3'd7, 1'b0);
    chk("abort_sel_kept", 0, int'(sel0), 6);
    start_abort_idle();
`ifdef STROBE_SEQ_DIR_EN
    run_burst(3'd1, 3'd2, 1'b1);
`endif

    for (int b = 0; b < 150; b++) begin
      for (int i = 1; i < 40; i++) hv[i] = ($urandom_range(0, 3) == 0);
      for (int i = 1; i < 60; i++) av[i] = ($urandom_range(0, 49) == 0);
`ifdef STROBE_SEQ_DIR_EN
      dn = 1'($urandom_range(0, 1));
`else
      dn = 1'b0;
`endif
      run_burst(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), dn);
      if ($urandom_range(0, 9) == 0) start_abort_idle();
      repeat ($urandom_range(0, 2)) begin
        next_cyc();
        idle_exp(cyc);
      end
    end

    repeat (3) begin
      next_cyc();
      idle_exp(cyc);
    end
    @(negedge sysclk);
    #1;
    chk("queue_empty", 0, q0.size(), 0);
    chk("queue_empty", 2, q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
